// File: rtl/cpu_mem_arbiter.sv
// Shares one memory port between fetch (port 0) and LSU (port 1); the grant is presented to memory in the same cycle it is decided.
// A request stalls in ISSUE until memory accepts it; one transaction is in flight at a time.
module cpu_mem_arbiter #(
    parameter int PRIORITY = 0
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_p0_req,
    input  logic [31:0] i_p0_addr,
    output logic        o_p0_ready,
    output logic [31:0] o_p0_data,
    output logic        o_p0_valid,
    input  logic        i_p1_req,
    input  logic [31:0] i_p1_addr,
    input  logic        i_p1_wr_en,
    input  logic [31:0] i_p1_wr_data,
    input  logic [3:0]  i_p1_wr_mask,
    output logic        o_p1_ready,
    output logic [31:0] o_p1_data,
    output logic        o_p1_valid,
    output logic        o_mem_req,
    output logic [31:0] o_mem_addr,
    output logic        o_mem_wr_en,
    output logic [31:0] o_mem_wr_data,
    output logic [3:0]  o_mem_wr_mask,
    input  logic        i_mem_ready,
    input  logic [31:0] i_mem_data,
    input  logic        i_mem_valid,
    output logic        o_busy,
    output logic        o_spurious
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   owner_q, owner_d;
    logic   last_q, last_d;
    logic   spurious_q, spurious_d;

    logic   winner;
    logic   sel;
    logic   sel_req;
    logic   present;
    logic   accept;
    logic   resp;

    always_comb begin
        winner = 1'b0;
        if (i_p0_req && i_p1_req) begin
            winner = (PRIORITY != 0) ? 1'b1 : ~last_q;
        end else if (i_p1_req) begin
            winner = 1'b1;
        end
        // Once locked, the owner keeps the bus even if the other port would win a fresh tie.
        sel     = (state_q == IDLE) ? winner : owner_q;
        sel_req = sel ? i_p1_req : i_p0_req;
        present = ((state_q == IDLE) || (state_q == ISSUE)) && sel_req;
        accept  = present && i_mem_ready;
        resp    = (state_q == WAIT) && i_mem_valid;
    end

    always_comb begin
        o_mem_req     = present;
        o_mem_addr    = 32'd0;
        o_mem_wr_en   = 1'b0;
        o_mem_wr_data = 32'd0;
        o_mem_wr_mask = 4'd0;
        if (present) begin
            if (sel) begin
                o_mem_addr    = i_p1_addr;
                o_mem_wr_en   = i_p1_wr_en;
                o_mem_wr_data = i_p1_wr_data;
                o_mem_wr_mask = i_p1_wr_mask;
            end else begin
                o_mem_addr    = i_p0_addr;
            end
        end
        o_p0_ready = accept && !sel;
        o_p1_ready = accept && sel;
        o_p0_valid = resp && !owner_q;
        o_p1_valid = resp && owner_q;
        o_p0_data  = o_p0_valid ? i_mem_data : 32'd0;
        o_p1_data  = o_p1_valid ? i_mem_data : 32'd0;
        o_busy     = (state_q != IDLE);
        o_spurious = spurious_q;
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_d     = last_q;
        spurious_d = spurious_q || (i_mem_valid && (state_q != WAIT));
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = WAIT;
                    owner_d = sel;
                    last_d  = sel;
                end else if (present) begin
                    state_d = ISSUE;
                    owner_d = sel;
                end
            end
            ISSUE: begin
                if (!sel_req) begin
                    state_d = IDLE;
                end else if (accept) begin
                    state_d = WAIT;
                    last_d  = owner_q;
                end
            end
            WAIT: begin
                if (i_mem_valid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= IDLE;
            owner_q    <= 1'b0;
            last_q     <= 1'b1;
            spurious_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            spurious_q <= spurious_d;
        end
    end

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Directed bench for cpu_mem_arbiter: instance 0 runs round-robin, instance 1 fixed priority, on shared stimulus.
module tb_cpu_mem_arbiter;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_p0_req;
    logic [31:0] i_p0_addr;
    logic        i_p1_req;
    logic [31:0] i_p1_addr;
    logic        i_p1_wr_en;
    logic [31:0] i_p1_wr_data;
    logic [3:0]  i_p1_wr_mask;
    logic        i_mem_ready;
    logic [31:0] i_mem_data;
    logic        i_mem_valid;

    logic        o_p0_ready    [2];
    logic [31:0] o_p0_data     [2];
    logic        o_p0_valid    [2];
    logic        o_p1_ready    [2];
    logic [31:0] o_p1_data     [2];
    logic        o_p1_valid    [2];
    logic        o_mem_req     [2];
    logic [31:0] o_mem_addr    [2];
    logic        o_mem_wr_en   [2];
    logic [31:0] o_mem_wr_data [2];
    logic [3:0]  o_mem_wr_mask [2];
    logic        o_busy        [2];
    logic        o_spurious    [2];

    int vectors = 0;
    int miscompares = 0;
    int acc_p0 [2];
    int acc_p1 [2];

    always #5 i_clk = ~i_clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        cpu_mem_arbiter #(.PRIORITY(g)) u_dut (
            .i_clk        (i_clk),
            .i_rst        (i_rst),
            .i_p0_req     (i_p0_req),
            .i_p0_addr    (i_p0_addr),
            .o_p0_ready   (o_p0_ready[g]),
            .o_p0_data    (o_p0_data[g]),
            .o_p0_valid   (o_p0_valid[g]),
            .i_p1_req     (i_p1_req),
            .i_p1_addr    (i_p1_addr),
            .i_p1_wr_en   (i_p1_wr_en),
            .i_p1_wr_data (i_p1_wr_data),
            .i_p1_wr_mask (i_p1_wr_mask),
            .o_p1_ready   (o_p1_ready[g]),
            .o_p1_data    (o_p1_data[g]),
            .o_p1_valid   (o_p1_valid[g]),
            .o_mem_req    (o_mem_req[g]),
            .o_mem_addr   (o_mem_addr[g]),
            .o_mem_wr_en  (o_mem_wr_en[g]),
            .o_mem_wr_data(o_mem_wr_data[g]),
            .o_mem_wr_mask(o_mem_wr_mask[g]),
            .i_mem_ready  (i_mem_ready),
            .i_mem_data   (i_mem_data),
            .i_mem_valid  (i_mem_valid),
            .o_busy       (o_busy[g]),
            .o_spurious   (o_spurious[g])
        );
    end

    task automatic cyc();
        @(posedge i_clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk1(input string tag, input int k, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s[dut%0d] observed=%b expected=%b", tag, k, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s[dut%0d] observed=%h expected=%h", tag, k, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        i_p0_req     = 1'b0;
        i_p0_addr    = 32'd0;
        i_p1_req     = 1'b0;
        i_p1_addr    = 32'd0;
        i_p1_wr_en   = 1'b0;
        i_p1_wr_data = 32'd0;
        i_p1_wr_mask = 4'd0;
        i_mem_ready  = 1'b0;
        i_mem_data   = 32'd0;
        i_mem_valid  = 1'b0;
    endtask

    initial begin
        logic exp_own;
        idle_inputs();
        i_rst = 1'b1;
        cyc();
        cyc();
        i_rst = 1'b0;
        settle();
        for (int k = 0; k < 2; k++) begin
            chk1("rst_busy", k, o_busy[k], 1'b0);
            chk1("rst_spurious", k, o_spurious[k], 1'b0);
            chk1("rst_mem_req", k, o_mem_req[k], 1'b0);
            chk32("rst_mem_addr", k, o_mem_addr[k], 32'd0);
            chk1("rst_p0_valid", k, o_p0_valid[k], 1'b0);
            chk1("rst_p1_ready", k, o_p1_ready[k], 1'b0);
        end

        // Single read from port 0
        i_p0_req = 1'b1; i_p0_addr = 32'h100; i_mem_ready = 1'b1;
        settle();
        for (int k = 0; k < 2; k++) begin
            chk1("rd_mem_req", k, o_mem_req[k], 1'b1);
            chk32("rd_mem_addr", k, o_mem_addr[k], 32'h100);
            chk1("rd_mem_wr_en", k, o_mem_wr_en[k], 1'b0);
            chk1("rd_p0_ready", k, o_p0_ready[k], 1'b1);
            chk1("rd_p1_ready", k, o_p1_ready[k], 1'b0);
        end
        cyc();
        i_p0_req = 1'b0; i_mem_ready = 1'b0;
        settle();
        for (int k = 0; k < 2; k++) begin
            chk1("rd_wait_busy", k, o_busy[k], 1'b1);
            chk1("rd_wait_mem_req", k, o_mem_req[k], 1'b0);
            chk1("rd_wait_p0_valid", k, o_p0_valid[k], 1'b0);
        end
        cyc();
        i_mem_valid = 1'b1; i_mem_data = 32'hDEADBEEF;
        settle();
        for (int k = 0; k < 2; k++) begin
            chk1("rd_p0_valid", k, o_p0_valid[k], 1'b1);
            chk32("rd_p0_data", k, o_p0_data[k], 32'hDEADBEEF);
            chk1("rd_p1_valid", k, o_p1_valid[k], 1'b0);
            chk32("rd_p1_data", k, o_p1_data[k], 32'd0);
        end
        cyc();
        idle_inputs();
        settle();
        for (int k = 0; k < 2; k++) begin
            chk1("rd_done_busy", k, o_busy[k], 1'b0);
            chk1("rd_done_spurious", k, o_spurious[k], 1'b0);
        end

        // Contention from reset with single-cycle memory
        i_rst = 1'b1;
        cyc();
        i_rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            acc_p0[k] = 0;
            acc_p1[k] = 0;
        end
        for (int i = 0; i < 4; i++) begin
            i_p0_req = 1'b1; i_p0_addr = 32'h300;
            i_p1_req = 1'b1; i_p1_addr = 32'h400;
            i_mem_ready = 1'b1; i_mem_valid = 1'b0;
            settle();
            for (int k = 0; k < 2; k++) begin
                exp_own = (k == 1) ? 1'b1 : ((i % 2) == 1);
                chk1("tie_p0_ready", k, o_p0_ready[k], !exp_own);
                chk1("tie_p1_ready", k, o_p1_ready[k], exp_own);
                chk32("tie_mem_addr", k, o_mem_addr[k], exp_own ? 32'h400 : 32'h300);
                if (o_p0_ready[k]) acc_p0[k]++;
                if (o_p1_ready[k]) acc_p1[k]++;
            end
            cyc();
            i_mem_valid = 1'b1; i_mem_data = 32'hA000_0000 + 32'(i);
            settle();
            for (int k = 0; k < 2; k++) begin
                exp_own = (k == 1) ? 1'b1 : ((i % 2) == 1);
                chk1("tie_p0_valid", k, o_p0_valid[k], !exp_own);
                chk1("tie_p1_valid", k, o_p1_valid[k], exp_own);
                chk32("tie_rsp_data", k, exp_own ? o_p1_data[k] : o_p0_data[k], 32'hA000_0000 + 32'(i));
            end
            cyc();
        end
        for (int k = 0; k < 2; k++) begin
            chk32("tie_acc_p0", k, 32'(acc_p0[k]), (k == 0) ? 32'd2 : 32'd0);
            chk32("tie_acc_p1", k, 32'(acc_p1[k]), (k == 0) ? 32'd2 : 32'd4);
            chk1("tie_spurious", k, o_spurious[k], 1'b0);
        end
        idle_inputs();

        // Port 1 write
        i_p1_req = 1'b1; i_p1_addr = 32'h200; i_p1_wr_en = 1'b1;
        i_p1_wr_data = 32'h12345678; i_p1_wr_mask = 4'hF; i_mem_ready = 1'b1;
        settle();
        for (int k = 0; k < 2; k++) begin
            chk1("wr_p1_ready", k, o_p1_ready[k], 1'b1);
            chk1("wr_mem_wr_en", k, o_mem_wr_en[k], 1'b1);
            chk32("wr_mem_addr", k, o_mem_addr[k], 32'h200);
            chk32("wr_mem_wr_data", k, o_mem_wr_data[k], 32'h12345678);
            chk32("wr_mem_wr_mask", k, 32'(o_mem_wr_mask[k]), 32'hF);
        end
        cyc();
        idle_inputs();
        cyc();
        i_mem_valid = 1'b1;
        settle();
        for (int k = 0; k < 2; k++) begin
            chk1("wr_p1_valid", k, o_p1_valid[k], 1'b1);
            chk1("wr_p0_valid", k, o_p0_valid[k], 1'b0);
        end
        cyc();
        idle_inputs();

        // Locked port 0 is not preempted by a later port 1 request
        i_p0_req = 1'b1; i_p0_addr = 32'h500;
        i_p1_addr = 32'h600; i_p1_wr_en = 1'b1; i_p1_wr_data = 32'hAAAA5555; i_p1_wr_mask = 4'h3;
        settle();
        for (int k = 0; k < 2; k++) begin
            chk1("lock_mem_req", k, o_mem_req[k], 1'b1);
            chk32("lock_mem_addr0", k, o_mem_addr[k], 32'h500);
            chk32("lock_wr_data0", k, o_mem_wr_data[k], 32'd0);
            chk1("lock_p0_ready0", k, o_p0_ready[k], 1'b0);
        end
        cyc();
        i_p1_req = 1'b1;
        for (int c = 0; c < 2; c++) begin
            settle();
            for (int k = 0; k < 2; k++) begin
                chk32("lock_mem_addr", k, o_mem_addr[k], 32'h500);
                chk1("lock_wr_en", k, o_mem_wr_en[k], 1'b0);
                chk1("lock_p1_ready", k, o_p1_ready[k], 1'b0);
                chk1("lock_busy", k, o_busy[k], 1'b1);
            end
            cyc();
        end
        i_mem_ready = 1'b1;
        settle();
        for (int k = 0; k < 2; k++) begin
            chk1("lock_p0_ready", k, o_p0_ready[k], 1'b1);
            chk1("lock_p1_ready_acc", k, o_p1_ready[k], 1'b0);
            chk32("lock_acc_addr", k, o_mem_addr[k], 32'h500);
        end
        cyc();
        i_p0_req = 1'b0; i_mem_ready = 1'b0;
        cyc();
        i_mem_valid = 1'b1; i_mem_data = 32'h0000_BEEF;
        settle();
        for (int k = 0; k < 2; k++) begin
            chk1("lock_rsp_p0_valid", k, o_p0_valid[k], 1'b1);
            chk1("lock_rsp_p1_ready", k, o_p1_ready[k], 1'b0);
            chk1("lock_rsp_mem_req", k, o_mem_req[k], 1'b0);
        end
        cyc();
        i_mem_valid = 1'b0; i_mem_ready = 1'b1;
        settle();
        for (int k = 0; k < 2; k++) begin
            chk1("lock_next_p1_ready", k, o_p1_ready[k], 1'b1);
            chk32("lock_next_addr", k, o_mem_addr[k], 32'h600);
            chk32("lock_next_wr_data", k, o_mem_wr_data[k], 32'hAAAA5555);
            chk32("lock_next_wr_mask", k, 32'(o_mem_wr_mask[k]), 32'h3);
        end
        cyc();
        idle_inputs();
        cyc();
        i_mem_valid = 1'b1;
        cyc();
        idle_inputs();

        // Response with nothing outstanding
        i_mem_valid = 1'b1; i_mem_data = 32'h55;
        settle();
        for (int k = 0; k < 2; k++) begin
            chk1("spur_p0_valid", k, o_p0_valid[k], 1'b0);
            chk1("spur_p1_valid", k, o_p1_valid[k], 1'b0);
            chk32("spur_p0_data", k, o_p0_data[k], 32'd0);
        end
        cyc();
        idle_inputs();
        settle();
        for (int k = 0; k < 2; k++) chk1("spur_set", k, o_spurious[k], 1'b1);
        cyc();
        for (int k = 0; k < 2; k++) chk1("spur_sticky", k, o_spurious[k], 1'b1);

        // Reset while a response is pending
        i_p0_req = 1'b1; i_p0_addr = 32'h900; i_mem_ready = 1'b1;
        cyc();
        idle_inputs();
        settle();
        for (int k = 0; k < 2; k++) chk1("rstw_busy_before", k, o_busy[k], 1'b1);
        i_rst = 1'b1;
        cyc();
        i_rst = 1'b0;
        settle();
        for (int k = 0; k < 2; k++) begin
            chk1("rstw_busy", k, o_busy[k], 1'b0);
            chk1("rstw_spurious", k, o_spurious[k], 1'b0);
        end

        // Locked owner withdraws; waiting port 1 gets the next cycle
        i_p0_req = 1'b1; i_p0_addr = 32'h700;
        cyc();
        i_p0_req = 1'b0; i_p1_req = 1'b1; i_p1_addr = 32'h800;
        settle();
        for (int k = 0; k < 2; k++) begin
            chk1("wd_mem_req", k, o_mem_req[k], 1'b0);
            chk1("wd_p1_ready", k, o_p1_ready[k], 1'b0);
            chk1("wd_busy", k, o_busy[k], 1'b1);
        end
        cyc();
        i_mem_ready = 1'b1;
        settle();
        for (int k = 0; k < 2; k++) begin
            chk1("wd_busy_after", k, o_busy[k], 1'b0);
            chk1("wd_grant_p1", k, o_p1_ready[k], 1'b1);
            chk32("wd_grant_addr", k, o_mem_addr[k], 32'h800);
        end
        cyc();
        idle_inputs();
        cyc();
        i_mem_valid = 1'b1; i_mem_data = 32'h0BAD_F00D;
        settle();
        for (int k = 0; k < 2; k++) chk32("wd_p1_data", k, o_p1_data[k], 32'h0BAD_F00D);
        cyc();
        idle_inputs();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cpu_mem_arbiter.md
Name:
cpu_mem_arbiter

Overview:
- Two-port arbiter that shares the CPU's single memory interface between the instruction fetch unit (port 0) and the load/store unit (port 1).
- Presents one request at a time to memory and holds the selected request stable until memory accepts it.
- Tracks the single outstanding transaction and routes the memory response back to the port that issued it.
- Sits between the fetch/LSU stages and the memory system; both ports use the same ready/valid request-response protocol as the memory interface.

Parameters:
- PRIORITY, 0, tie-break mode: 0 = round-robin, 1 = fixed priority with port 1 winning ties.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_p0_req  in  1  port 0 (fetch) read request
- i_p0_addr  in  32  port 0 address
- o_p0_ready  out  1  port 0 request accepted this cycle
- o_p0_data  out  32  port 0 read data
- o_p0_valid  out  1  port 0 response valid
- i_p1_req  in  1  port 1 (LSU) request
- i_p1_addr  in  32  port 1 address
- i_p1_wr_en  in  1  port 1 request is a write
- i_p1_wr_data  in  32  port 1 write data
- i_p1_wr_mask  in  4  port 1 byte-enable mask
- o_p1_ready  out  1  port 1 request accepted this cycle
- o_p1_data  out  32  port 1 read data
- o_p1_valid  out  1  port 1 response valid (read data or write completion)
- o_mem_req  out  1  request presented to memory
- o_mem_addr  out  32  memory address
- o_mem_wr_en  out  1  memory write
- o_mem_wr_data  out  32  memory write data
- o_mem_wr_mask  out  4  memory byte mask
- i_mem_ready  in  1  memory accepts the presented request this cycle
- i_mem_data  in  32  memory read data
- i_mem_valid  in  1  memory response valid (one pulse per accepted request, including writes)
- o_busy  out  1  state != IDLE
- o_spurious  out  1  sticky: i_mem_valid seen with no outstanding request

Behaviour:
- Reset (i_rst sampled high at posedge):
  - state = IDLE; r_last = port 1, so port 0 wins the first tie.
  - o_spurious = 0; all outputs are 0 in the cycle after reset.
  - Any outstanding transaction is abandoned; the memory system shares i_rst.
- States:
  - IDLE: no request is locked.
  - ISSUE: a request is locked and being presented, not yet accepted.
  - WAIT: a request has been accepted and its response is pending.
- Selection in IDLE (combinational):
  - Only one port requesting: that port wins.
  - Both requesting with PRIORITY=0: the port != r_last wins.
  - Both requesting with PRIORITY=1: port 1 wins.
- Request presentation:
  - In IDLE with any request, the winner's fields drive o_mem_* in the same cycle (zero latency).
  - o_mem_req = 1.
  - For port 0: o_mem_wr_en = 0, o_mem_wr_data = 0, o_mem_wr_mask = 0.
- Acceptance:
  - Occurs when o_mem_req & i_mem_ready.
  - The winner's o_pX_ready = 1 in that same cycle; only one o_pX_ready is ever high.
  - The owner register is latched, r_last = owner, and the next state is WAIT.
- Not accepted in IDLE:
  - The winner is locked into r_owner; next state is ISSUE.
  - In ISSUE, o_mem_* come from the locked owner's live inputs.
  - The other port cannot preempt the locked owner, even under fixed priority.
  - Acceptance in ISSUE follows the same rules as in IDLE.
- Request withdrawal:
  - Requesters must hold req and fields until ready.
  - If the locked owner drops req in ISSUE, o_mem_req = 0 that cycle and the next state is IDLE; r_last is unchanged.
- WAIT:
  - o_mem_req = 0; both o_pX_ready = 0.
  - On i_mem_valid, the owner's o_pX_valid = 1 and o_pX_data = i_mem_data, combinationally in the same cycle; the next state is IDLE.
  - A new request can be presented no earlier than the cycle after the response (one bubble cycle).
- Non-owner outputs: the non-owner's o_pX_valid is 0 and its o_pX_data is 0 at all times.
- Spurious response: i_mem_valid in IDLE or ISSUE is ignored (no o_pX_valid) and sets o_spurious, which clears only on reset.
- Back-to-back: acceptance and response can never occur in the same cycle, because acceptance only happens in IDLE/ISSUE and responses only in WAIT.
- Throughput: at most one transaction per 2 cycles with single-cycle memory.

Test Plan:
- Single read, port 0 only: p0_req, addr=0x100, mem_ready=1 at cycle 0; mem_valid with data=0xDEADBEEF at cycle 2 -> o_p0_ready at cycle 0, o_p0_valid with data 0xDEADBEEF at cycle 2, o_p1_valid=0 throughout.
- Round-robin (PRIORITY=0), both ports requesting continuously with single-cycle memory -> grants alternate p0, p1, p0, p1 starting with p0 after reset; each port gets 2 of 4 accepts in 8 cycles.
- Fixed priority (PRIORITY=1), both requesting -> p1 wins every tie. Lock check: p0 alone with mem_ready=0 for 3 cycles, p1 raises req at cycle 1 -> o_mem_addr stays p0's address until p0 is accepted.
- Port 1 write: addr=0x200, wr_data=0x12345678, mask=0xF -> o_mem_wr_en=1 with matching data/mask on accept; the completion pulse gives o_p1_valid=1.
- Spurious and reset: mem_valid in IDLE -> o_spurious=1 and no port valid. Reset asserted in WAIT -> IDLE, o_busy=0 and o_spurious=0 next cycle.
- Withdrawal: p0 locked in ISSUE drops req -> o_mem_req=0 that cycle, state IDLE, and a waiting p1 is granted next cycle.
